// File: rtl/mips32_reg_dump_if.sv
// rtl/mips32_reg_dump_if.sv - register-file read port and dump word stream for mips32_reg_dump
interface mips32_reg_dump_if;
  logic        rf_re;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output rf_re,
    output rf_raddr,
    input  rf_rdata,
    output out_valid,
    input  out_ready,
    output out_index,
    output out_data,
    output out_last
  );

  modport slave (
    input  rf_re,
    input  rf_raddr,
    output rf_rdata,
    input  out_valid,
    output out_ready,
    input  out_index,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/mips32_reg_dump.sv
// rtl/mips32_reg_dump.sv - on halt rising edge, streams registers FIRST_REG..LAST_REG out of the register file
module mips32_reg_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  output logic              busy,
  output logic              done,
  mips32_reg_dump_if.master bus
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic [4:0]  index_q, index_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_index_q, out_index_d;

  logic rf_re;
  logic out_valid;
  logic out_last;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      halted_q    <= 1'b0;
      index_q     <= FIRST_IDX;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      index_q     <= index_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halted_d    = halted;
    index_d     = index_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    rf_re       = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a fresh 0->1 edge seen while idle arms a dump.
        if (halted && !halted_q) begin
          state_d = READ;
          index_d = FIRST_IDX;
        end
      end
      READ: begin
        rf_re   = 1'b1;
        busy    = 1'b1;
        state_d = CAPT;
      end
      CAPT: begin
        busy        = 1'b1;
        out_data_d  = bus.rf_rdata;
        out_index_d = index_q;
        state_d     = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (index_q == LAST_IDX);
        if (bus.out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            index_d = index_q + 5'd1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (!halted) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rf_re     = rf_re;
  assign bus.rf_raddr  = index_q;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

endmodule

// File: tb/tb_mips32_reg_dump.sv
// tb/tb_mips32_reg_dump.sv - scoreboard bench for mips32_reg_dump (short 0..5 dump and full 0..31 dump)
module tb_mips32_reg_dump;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rsta, ha, rdya, busy_a, done_a;
  logic rstb, hb, rdyb, busy_b, done_b;

  mips32_reg_dump_if bus_a();
  mips32_reg_dump_if bus_b();

  assign bus_a.out_ready = rdya;
  assign bus_b.out_ready = rdyb;

  mips32_reg_dump #(.FIRST_REG(0), .LAST_REG(5)) dut_a (
    .clk1   (clk),
    .rst_n  (rsta),
    .halted (ha),
    .busy   (busy_a),
    .done   (done_a),
    .bus    (bus_a)
  );

  mips32_reg_dump dut_b (
    .clk1   (clk),
    .rst_n  (rstb),
    .halted (hb),
    .busy   (busy_b),
    .done   (done_b),
    .bus    (bus_b)
  );

  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  always @(posedge clk) begin
    if (bus_a.rf_re) bus_a.rf_rdata <= regs_a[bus_a.rf_raddr];
    if (bus_b.rf_re) bus_b.rf_rdata <= regs_b[bus_b.rf_raddr];
  end

  int n_vec = 0;
  int n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input int i);
    exp_t e;
    e.idx  = 5'(i);
    e.data = regs_a[i];
    e.last = (i == 5);
    q_a.push_back(e);
  endtask

  task automatic push_b(input int i);
    exp_t e;
    e.idx  = 5'(i);
    e.data = regs_b[i];
    e.last = (i == 31);
    q_b.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  // Scoreboard monitor for the short dump, including hold-stable checks during stalls.
  logic        stall_a = 1'b0;
  logic [31:0] sav_data_a;
  logic [4:0]  sav_idx_a;
  exp_t        ea;
  always @(negedge clk) begin
    if (stall_a) begin
      chk("a_stall_valid", 64'(bus_a.out_valid), 64'd1);
      chk("a_stall_data", 64'(bus_a.out_data), 64'(sav_data_a));
      chk("a_stall_index", 64'(bus_a.out_index), 64'(sav_idx_a));
    end
    if (bus_a.out_valid && rdya) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_word: got index %0d data %0d, want no word", bus_a.out_index, bus_a.out_data);
      end else begin
        ea = q_a.pop_front();
        chk("a_index", 64'(bus_a.out_index), 64'(ea.idx));
        chk("a_data", 64'(bus_a.out_data), 64'(ea.data));
        chk("a_last", 64'(bus_a.out_last), 64'(ea.last));
      end
    end
    stall_a    <= bus_a.out_valid && !rdya;
    sav_data_a <= bus_a.out_data;
    sav_idx_a  <= bus_a.out_index;
  end

  exp_t eb;
  always @(negedge clk) begin
    if (bus_b.out_valid && rdyb) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_word: got index %0d data %0h, want no word", bus_b.out_index, bus_b.out_data);
      end else begin
        eb = q_b.pop_front();
        chk("b_index", 64'(bus_b.out_index), 64'(eb.idx));
        chk("b_data", 64'(bus_b.out_data), 64'(eb.data));
        chk("b_last", 64'(bus_b.out_last), 64'(eb.last));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first_v, first_d, ndone;
    bit  found;

    for (int i = 0; i < 32; i++) begin
      regs_a[i] = 32'd0;
      regs_b[i] = 32'h1000_0000 + 32'(i) * 32'h0011_0001;
    end
    regs_a[1] = 32'd10;
    regs_a[2] = 32'd20;
    regs_a[3] = 32'd25;
    regs_a[4] = 32'd30;
    regs_a[5] = 32'd55;

    rsta = 1'b0; rstb = 1'b0; ha = 1'b0; hb = 1'b0; rdya = 1'b1; rdyb = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_rf_re", 64'(bus_a.rf_re), 64'd0);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus_a.out_last), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_out_data", 64'(bus_a.out_data), 64'd0);
    chk("rst_out_index", 64'(bus_a.out_index), 64'd0);
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    step();
    rsta = 1'b1; rstb = 1'b1;
    repeat (2) step();

    // Basic dump with latency and completion timing.
    for (int i = 0; i <= 5; i++) push_a(i);
    ha = 1'b1;
    first_v = -1; first_d = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (first_v < 0 && bus_a.out_valid) first_v = k;
      if (done_a) begin
        first_d = k;
        break;
      end
    end
    chk("t1_first_valid_cycle", 64'(first_v), 64'd3);
    chk("t1_done_cycle", 64'(first_d), 64'd19);
    chk("t1_queue_empty", 64'(q_a.size()), 64'd0);
    step();
    ha = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("t1_idle_done", 64'(done_a), 64'd0);
    chk("t1_idle_busy", 64'(busy_a), 64'd0);

    // Back-pressure on the index-2 word.
    for (int i = 0; i <= 5; i++) push_a(i);
    step();
    ha = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_a.rf_re && bus_a.rf_raddr == 5'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t2_found_read2", 64'(found), 64'd1);
    step();
    rdya = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(bus_a.out_valid), 64'd1);
      chk("t2_hold_data", 64'(bus_a.out_data), 64'd20);
      chk("t2_hold_index", 64'(bus_a.out_index), 64'd2);
    end
    step();
    rdya = 1'b1;
    wait_done_a("t2_done_seen");
    chk("t2_queue_empty", 64'(q_a.size()), 64'd0);
    step();
    ha = 1'b0;
    repeat (2) step();

    // Halt drops mid-dump: dump completes, done is a single pulse.
    for (int i = 0; i <= 5; i++) push_a(i);
    ha = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_a.out_valid && bus_a.out_index == 5'd3) begin
        ha = 1'b0;
        found = 1'b1;
        break;
      end
    end
    chk("t3_found_send3", 64'(found), 64'd1);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("t3_done_pulse_len", 64'(ndone), 64'd1);
    chk("t3_idle_busy", 64'(busy_a), 64'd0);
    chk("t3_queue_empty", 64'(q_a.size()), 64'd0);

    // Reset while index 2 is being captured; halt held high re-triggers.
    push_a(0);
    push_a(1);
    step();
    ha = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy_a && !bus_a.rf_re && !bus_a.out_valid && bus_a.rf_raddr == 5'd2) begin
        rsta = 1'b0;
        found = 1'b1;
        break;
      end
    end
    chk("t4_found_capt2", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    rsta = 1'b1;
    @(negedge clk);
    chk("t4_post_rst_valid", 64'(bus_a.out_valid), 64'd0);
    chk("t4_post_rst_busy", 64'(busy_a), 64'd0);
    chk("t4_post_rst_done", 64'(done_a), 64'd0);
    chk("t4_post_rst_rf_re", 64'(bus_a.rf_re), 64'd0);
    chk("t4_queue_drained", 64'(q_a.size()), 64'd0);
    for (int i = 0; i <= 5; i++) push_a(i);
    wait_done_a("t4_done_seen");
    chk("t4_queue_empty", 64'(q_a.size()), 64'd0);

    // Done held while halted; a 1->0->1 pulse gives exactly one more dump.
    repeat (5) @(negedge clk);
    chk("t5_done_held", 64'(done_a), 64'd1);
    for (int i = 0; i <= 5; i++) push_a(i);
    step();
    ha = 1'b0;
    step();
    ha = 1'b1;
    wait_done_a("t5_done_seen");
    chk("t5_queue_empty", 64'(q_a.size()), 64'd0);
    repeat (20) @(negedge clk);
    chk("t5_done_still", 64'(done_a), 64'd1);
    chk("t5_busy_still", 64'(busy_a), 64'd0);
    step();
    ha = 1'b0;
    repeat (2) step();

    // Full 32-register dump with default parameters.
    for (int i = 0; i < 32; i++) push_b(i);
    hb = 1'b1;
    first_v = -1; first_d = -1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (first_v < 0 && bus_b.out_valid) first_v = k;
      if (done_b) begin
        first_d = k;
        break;
      end
    end
    chk("t6_first_valid_cycle", 64'(first_v), 64'd3);
    chk("t6_done_cycle", 64'(first_d), 64'd97);
    chk("t6_queue_empty", 64'(q_b.size()), 64'd0);
    chk("t6_final_index", 64'(bus_b.out_index), 64'd31);
    chk("t6_final_raddr", 64'(bus_b.rf_raddr), 64'd31);
    chk("t6_last_in_done", 64'(bus_b.out_last), 64'd0);
    step();
    hb = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips32_reg_dump.md
MIPS32_REG_DUMP -- requirements
Module: mips32_reg_dump

Interface
REQ-001 Parameter FIRST_REG, default 0, first register index dumped.
REQ-002 Parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 clk1  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 halted  input  1  core halt flag, level, synchronous to clk1.
REQ-006 rf_re  output  1  register-file read enable.
REQ-007 rf_raddr  output  5  register-file read address.
REQ-008 rf_rdata  input  32  read data; valid in the cycle after the rf_re cycle (synchronous read).
REQ-009 out_valid  output  1  dump word valid.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_index  output  5  register index of the current word.
REQ-012 out_data  output  32  register contents.
REQ-013 out_last  output  1  current word is LAST_REG.
REQ-014 busy  output  1  dump in progress.
REQ-015 done  output  1  dump complete; held until the core leaves halt.

Function
REQ-016 The FSM SHALL have states IDLE, READ, CAPT, SEND and DONE.
REQ-017 Trigger: halted_q is a registered copy of halted; a trigger occurs when halted=1 and halted_q=0 while in IDLE.
REQ-018 IDLE to READ on trigger; the index register is loaded with FIRST_REG.
REQ-019 In READ, rf_re=1 and rf_raddr=index for exactly one cycle; next state is CAPT.
REQ-020 In CAPT, rf_re=0; at the end of the cycle, rf_rdata is latched into out_data and index into out_index; next state is SEND.
REQ-021 In SEND, out_valid=1; out_data, out_index and out_last hold stable until out_valid and out_ready are both 1 at a clock edge.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready.
REQ-023 On handshake: if index==LAST_REG, go to DONE; otherwise index increments by 1 and the FSM returns to READ.
REQ-024 out_last=1 only in SEND when index==LAST_REG.
REQ-025 Latency: out_valid rises 3 cycles after the trigger edge.
REQ-026 Throughput with out_ready held at 1: one word per 3 cycles; 32 registers take 96 cycles from trigger to DONE.
REQ-027 busy=1 in READ, CAPT and SEND; 0 otherwise.
REQ-028 done=1 only in DONE.
REQ-029 DONE exits to IDLE in the first cycle in which halted=0.
REQ-030 If halted is already 0 on DONE entry, done is a single-cycle pulse.
REQ-031 halted deasserting during READ, CAPT or SEND is ignored; the dump completes.
REQ-032 A new halted rising edge during a dump or in DONE is ignored; re-arming requires a return to IDLE followed by a fresh 0-to-1 transition.
REQ-033 rf_raddr equals index in all states; rf_re=0 outside READ.
REQ-034 rf_rdata SHALL be sampled only at the end of CAPT.

Reset
REQ-035 When rst_n=0 at a clock edge, the state goes to IDLE, halted_q=0, and index=FIRST_REG.
REQ-036 Reset outputs: rf_re=0, out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_index=0.
REQ-037 Reset mid-dump aborts immediately; no partial word remains valid after the reset edge.
REQ-038 If halted=1 on the first cycle after reset release, a trigger occurs, because halted_q resets to 0.

Verification
REQ-039 Register file preloaded R1=10, R2=20, R3=25, R4=30, R5=55; FIRST_REG=0, LAST_REG=5; out_ready=1; halted 0->1 -> six words (0,0), (1,10), (2,20), (3,25), (4,30), (5,55); out_last only on index 5; done in the cycle after the 18th cycle from trigger.
REQ-040 Same setup, out_ready held 0 for 7 cycles on the word for index 2 -> out_valid stays 1 with out_data=20 and out_index=2 stable throughout; no skipped or duplicated index.
REQ-041 halted dropped to 0 while index=3 is in SEND -> dump still delivers indices 3-5; done is a single-cycle pulse; FSM returns to IDLE.
REQ-042 rst_n=0 for one cycle while index=2 is in CAPT -> the next cycle shows out_valid=0, busy=0 and state IDLE; with halted still 1, a new dump starts from index 0.
REQ-043 Second halted rising edge while in DONE (halted pulsed 1->0->1 after done) -> exactly one additional full dump.
REQ-044 Defaults FIRST_REG=0, LAST_REG=31, out_ready=1 -> 32 words, 96 cycles from trigger to DONE, and out_index wraps cleanly to 31 without overflow.
